// File: rtl/audio_frame_scheduler_if.sv
// Stream and sample-generator handshake bundle for the audio frame scheduler.
// master = scheduler side, slave = generator/FIFO side.
interface audio_frame_scheduler_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  sample_req;
    logic                  sample_ack;
    logic [DATA_WIDTH-1:0] sample_left;
    logic [DATA_WIDTH-1:0] sample_right;
    logic [DATA_WIDTH-1:0] audio_data;
    logic                  audio_id;
    logic                  audio_valid;
    logic                  audio_ready;

    modport master (
        output sample_req,
        output audio_data,
        output audio_id,
        output audio_valid,
        input  sample_ack,
        input  sample_left,
        input  sample_right,
        input  audio_ready
    );

    modport slave (
        input  sample_req,
        input  audio_data,
        input  audio_id,
        input  audio_valid,
        output sample_ack,
        output sample_left,
        output sample_right,
        output audio_ready
    );
endinterface

// File: rtl/audio_frame_scheduler.sv
// Paces stereo frames: every SAMPLE_DIV cycles it fetches one left/right pair
// from the generator and emits it as two tagged beats on the audio stream.
module audio_frame_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int SAMPLE_DIV = 512
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    audio_frame_scheduler_if.master       bus,
    output logic                          busy,
    output logic [15:0]                   overrun_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_SEND_L = 2'd2,
        ST_SEND_R = 2'd3
    } state_t;

    localparam logic [15:0] TICK_AT = 16'(SAMPLE_DIV - 1);

    state_t                r_state;
    logic [15:0]           r_frame_cnt;
    logic                  r_sample_req;
    logic [DATA_WIDTH-1:0] r_audio_data;
    logic                  r_audio_id;
    logic                  r_audio_valid;
    logic                  r_busy;
    logic [15:0]           r_overrun_cnt;
    logic [DATA_WIDTH-1:0] r_left;
    logic [DATA_WIDTH-1:0] r_right;
    logic                  w_tick;
    logic                  w_overrun;

    assign w_tick    = enable && (r_frame_cnt == TICK_AT);
    assign w_overrun = w_tick && (r_state != ST_IDLE) && (r_overrun_cnt != 16'hFFFF);

    assign bus.sample_req  = r_sample_req;
    assign bus.audio_data  = r_audio_data;
    assign bus.audio_id    = r_audio_id;
    assign bus.audio_valid = r_audio_valid;
    assign busy            = r_busy;
    assign overrun_count   = r_overrun_cnt;

    // Frame timer: free-runs while enabled, restarts from zero otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_cnt <= 16'd0;
        end else if (!enable || w_tick) begin
            r_frame_cnt <= 16'd0;
        end else begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Frame FSM with registered handshake/stream outputs and overrun counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_sample_req  <= 1'b0;
            r_audio_data  <= '0;
            r_audio_id    <= 1'b0;
            r_audio_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun_cnt <= 16'd0;
            r_left        <= '0;
            r_right       <= '0;
        end else begin
            // Ticks landing outside IDLE are dropped, including the one that
            // coincides with the right beat being accepted.
            if (w_overrun) begin
                r_overrun_cnt <= r_overrun_cnt + 16'd1;
            end else begin
                r_overrun_cnt <= r_overrun_cnt;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state      <= ST_REQ;
                        r_sample_req <= 1'b1;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.sample_ack) begin
                        r_left        <= bus.sample_left;
                        r_right       <= bus.sample_right;
                        r_state       <= ST_SEND_L;
                        r_sample_req  <= 1'b0;
                        r_audio_valid <= 1'b1;
                        r_audio_id    <= 1'b0;
                        r_audio_data  <= bus.sample_left;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_SEND_L: begin
                    if (bus.audio_ready) begin
                        r_state      <= ST_SEND_R;
                        r_audio_id   <= 1'b1;
                        r_audio_data <= r_right;
                    end else begin
                        r_state <= ST_SEND_L;
                    end
                end
                ST_SEND_R: begin
                    if (bus.audio_ready) begin
                        r_state       <= ST_IDLE;
                        r_audio_valid <= 1'b0;
                        r_busy        <= 1'b0;
                    end else begin
                        r_state <= ST_SEND_R;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_sample_req  <= 1'b0;
                    r_audio_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/audio_frame_scheduler.md
AUDIO_FRAME_SCHEDULER -- requirements
Module: audio_frame_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of one audio sample word.
REQ-002 The block SHALL have parameter SAMPLE_DIV, default 512, clk cycles per stereo frame (24.576 MHz / 48 kHz); legal range 8..65535.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  frame pacing enable; 1 = frame timer runs.
REQ-006 sample_req  output  1  request for the next stereo sample pair from the generator.
REQ-007 sample_ack  input  1  generator handshake; sample_left/right valid in this cycle.
REQ-008 sample_left  input  DATA_WIDTH  left-channel sample, qualified by sample_ack.
REQ-009 sample_right  input  DATA_WIDTH  right-channel sample, qualified by sample_ack.
REQ-010 audio_data  output  DATA_WIDTH  stream data to audio FIFO.
REQ-011 audio_id  output  1  channel tag: 0 = left, 1 = right.
REQ-012 audio_valid  output  1  stream valid.
REQ-013 audio_ready  input  1  stream ready from audio FIFO.
REQ-014 busy  output  1  1 whenever state is not IDLE.
REQ-015 overrun_count  output  16  count of dropped frame ticks, saturating.

Function
REQ-016 Frame timer: 16-bit counter increments 0..SAMPLE_DIV-1 and wraps to 0 while enable=1; internal tick is high in the cycle counter == SAMPLE_DIV-1.
REQ-017 enable=0 SHALL clear the counter to 0 next cycle and suppress ticks; first tick occurs SAMPLE_DIV cycles after enable rises.
REQ-018 FSM states SHALL be IDLE, REQ, SEND_L, SEND_R.
REQ-019 IDLE -> REQ on tick; sample_req=1 from the following cycle (latency 1).
REQ-020 REQ: sample_req held 1 until sample_ack=1; that cycle latch sample_left/right, go to SEND_L; sample_req=0 from next cycle.
REQ-021 sample_ack outside REQ SHALL be ignored (no latch, no state change).
REQ-022 SEND_L: audio_valid=1, audio_id=0, audio_data=latched left; on audio_ready=1 go to SEND_R.
REQ-023 SEND_R: audio_valid=1, audio_id=1, audio_data=latched right; on audio_ready=1 go to IDLE.
REQ-024 audio_valid SHALL go high the cycle after the ack cycle, remain high continuously across both beats, and drop the cycle after the right beat is accepted.
REQ-025 While audio_valid=1 and audio_ready=0, audio_data and audio_id SHALL hold stable; valid SHALL never retract before acceptance.
REQ-026 A tick in any state other than IDLE SHALL be dropped and increment overrun_count by 1, saturating at 0xFFFF; this includes a tick coinciding with the right-beat acceptance.
REQ-027 enable falling mid-frame SHALL not abort the frame; REQ/SEND_L/SEND_R complete normally, then FSM stays IDLE.
REQ-028 All outputs SHALL be registered; busy = (state != IDLE) registered with state.

Reset
REQ-029 resetn=0 SHALL asynchronously force: state IDLE, counter 0, sample_req 0, audio_valid 0, audio_id 0, audio_data 0, latched samples 0, busy 0, overrun_count 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; no beat emitted after reset release until a new tick.
REQ-031 Release of resetn SHALL be synchronous-safe: first tick SAMPLE_DIV cycles after the first clk edge with resetn=1 and enable=1.

Verification (SAMPLE_DIV=8, DATA_WIDTH=32)
REQ-032 enable=1, ack 2 cycles after req, ready tied 1, left=0x11111111, right=0x22222222 -> beats (id0,0x11111111),(id1,0x22222222) on consecutive cycles, one pair per 8 cycles, overrun_count=0.
REQ-033 ready held 0 for 20 cycles during SEND_L -> data/id stable at left beat, valid high throughout, ticks during stall counted (overrun_count=2 or 3 as per tick cycles), then both beats delivered.
REQ-034 ack withheld for 30 cycles -> sample_req high continuously, overrun_count increments once per 8 cycles, no stream beats until ack.
REQ-035 enable dropped during SEND_L -> frame completes with both beats, no further sample_req; enable re-raised -> sample_req 9 cycles later (tick + 1).
REQ-036 resetn pulsed low during SEND_R -> audio_valid, sample_req, busy, overrun_count read 0 immediately; no right beat emitted afterwards.
REQ-037 Force 65540 overruns (ready stuck 0) -> overrun_count saturates at 0xFFFF.
